// File: rtl/md_issue_ctrl_if.sv
// Issue-control <-> pipeline / multiply-divide unit signal bundle.
// slave is the issue controller; master is the driving side (pipeline + MD unit).
interface md_issue_ctrl_if;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        md_busy;
  logic        stall;
  logic        md_mult;
  logic        md_multu;
  logic        md_div;
  logic        md_divu;
  logic        md_madd;
  logic        md_mthi;
  logic        md_mtlo;
  logic [31:0] md_data1;
  logic [31:0] md_data2;
  logic        div_zero;
  logic        wdog_err;

  modport slave (
    input  op_valid, op_code, rs_data, rt_data, flush, md_busy,
    output stall, md_mult, md_multu, md_div, md_divu, md_madd, md_mthi, md_mtlo,
    output md_data1, md_data2, div_zero, wdog_err
  );

  modport master (
    output op_valid, op_code, rs_data, rt_data, flush, md_busy,
    input  stall, md_mult, md_multu, md_div, md_divu, md_madd, md_mthi, md_mtlo,
    input  md_data1, md_data2, div_zero, wdog_err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: accepts E-stage MD ops, emits
// one-cycle start strobes with registered operands, stalls D/E until the unit is idle.
module md_issue_ctrl #(
  parameter int unsigned WDOG_MAX = 31
) (
  input  logic          clk,
  input  logic          reset,
  md_issue_ctrl_if.slave md
);

  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_GAP,
    S_BUSY
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [3:0]          r_op_code;
  logic [6:0]          r_strobe;
  logic [6:0]          w_strobe_nxt;
  logic [31:0]         r_data1;
  logic [31:0]         r_data2;
  logic                r_div_zero;
  logic                r_wdog_err;
  logic [WDOG_W-1:0]   r_wdog;
  logic                w_wdog_trip;
  logic                w_is_md;
  logic                w_is_issue;
  logic                w_accept;

  assign w_is_md    = (md.op_code >= 4'd1) && (md.op_code <= 4'd9);
  assign w_is_issue = (md.op_code >= 4'd1) && (md.op_code <= 4'd7);
  assign w_accept   = (r_state == S_IDLE) && md.op_valid && !md.flush && w_is_issue;

  // Gated by reset so the pipeline is never held while the block is in reset.
  assign md.stall = reset && md.op_valid && !md.flush && w_is_md &&
                    ((r_state != S_IDLE) || w_accept);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_wdog_trip = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_START;
      S_START: w_state_nxt = (r_op_code <= 4'd5) ? S_GAP : S_IDLE;
      S_GAP:   w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (!md.md_busy) begin
          w_state_nxt = S_IDLE;
        end else if (r_wdog == WDOG_W'(WDOG_MAX - 1)) begin
          w_wdog_trip = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe bit order: mult, multu, div, divu, madd, mthi, mtlo.
  always_comb begin
    w_strobe_nxt = '0;
    if (w_accept) begin
      case (md.op_code)
        4'd1:    w_strobe_nxt[0] = 1'b1;
        4'd2:    w_strobe_nxt[1] = 1'b1;
        4'd3:    w_strobe_nxt[2] = 1'b1;
        4'd4:    w_strobe_nxt[3] = 1'b1;
        4'd5:    w_strobe_nxt[4] = 1'b1;
        4'd6:    w_strobe_nxt[5] = 1'b1;
        4'd7:    w_strobe_nxt[6] = 1'b1;
        default: w_strobe_nxt = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op_code  <= '0;
      r_strobe   <= '0;
      // NOTE: operand registers are reset too, since they are visible outputs.
      r_data1    <= '0;
      r_data2    <= '0;
      r_div_zero <= 1'b0;
      r_wdog_err <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_strobe   <= w_strobe_nxt;
      r_div_zero <= w_accept && ((md.op_code == 4'd3) || (md.op_code == 4'd4)) &&
                    (md.rt_data == 32'd0);
      if (w_accept) begin
        r_op_code <= md.op_code;
        r_data1   <= md.rs_data;
        r_data2   <= md.rt_data;
      end
      if (r_state == S_GAP) begin
        r_wdog <= '0;
      end else if ((r_state == S_BUSY) && (r_wdog != WDOG_W'(WDOG_MAX))) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_wdog_trip) r_wdog_err <= 1'b1;
    end
  end

  assign md.md_mult  = r_strobe[0];
  assign md.md_multu = r_strobe[1];
  assign md.md_div   = r_strobe[2];
  assign md.md_divu  = r_strobe[3];
  assign md.md_madd  = r_strobe[4];
  assign md.md_mthi  = r_strobe[5];
  assign md.md_mtlo  = r_strobe[6];
  assign md.md_data1 = r_data1;
  assign md.md_data2 = r_data2;
  assign md.div_zero = r_div_zero;
  assign md.wdog_err = r_wdog_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: each task drives one scenario and checks it inline.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_md_issue_ctrl;

  localparam int unsigned WDOG = 31;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  md_issue_ctrl_if m ();

  md_issue_ctrl #(.WDOG_MAX(WDOG)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // {mtlo, mthi, madd, divu, div, multu, mult}
  function automatic logic [6:0] strobes();
    return {m.md_mtlo, m.md_mthi, m.md_madd, m.md_divu, m.md_div, m.md_multu, m.md_mult};
  endfunction

  task automatic drive(input logic v, input logic [3:0] code, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl, input logic busy);
    m.op_valid = v;
    m.op_code  = code;
    m.rs_data  = rs;
    m.rt_data  = rt;
    m.flush    = fl;
    m.md_busy  = busy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 4'd1, 32'h11, 32'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (m.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", m.stall); else n_pass++;
    n_checks++; if (strobes() !== 7'b0) $display("FAIL reset_strobes: got %b want 0", strobes()); else n_pass++;
    n_checks++; if ({m.div_zero, m.wdog_err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {m.div_zero, m.wdog_err}); else n_pass++;
    n_checks++; if ({m.md_data1, m.md_data2} !== 64'd0) $display("FAIL reset_data: got %h want 0", {m.md_data1, m.md_data2}); else n_pass++;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    next_cycle();
  endtask

  // MULT 3 * -2; md_busy high for cycles 2..7 after accept, so BUSY ends at cycle 8.
  task automatic test_mult();
    int n_strobe;
    n_strobe = 0;
    for (int c = 0; c < 12; c++) begin
      if (c <= 8)
        drive(1'b1, 4'd1, (c == 0) ? 32'd3 : 32'hDEAD0000 + c, (c == 0) ? 32'hFFFFFFFE : 32'h55,
              1'b0, (c >= 2) && (c <= 7));
      else
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (m.md_mult) n_strobe++;
      n_checks++; if (m.stall !== (c <= 8)) $display("FAIL mult_stall c%0d: got %b want %b", c, m.stall, (c <= 8)); else n_pass++;
      n_checks++; if (strobes() !== ((c == 1) ? 7'b0000001 : 7'b0)) $display("FAIL mult_strobes c%0d: got %b want %b", c, strobes(), (c == 1) ? 7'b0000001 : 7'b0); else n_pass++;
      if ((c >= 1) && (c <= 8)) begin
        n_checks++; if ({m.md_data1, m.md_data2} !== {32'd3, 32'hFFFFFFFE}) $display("FAIL mult_data c%0d: got %h want %h", c, {m.md_data1, m.md_data2}, {32'd3, 32'hFFFFFFFE}); else n_pass++;
      end
      next_cycle();
    end
    n_checks++; if (n_strobe !== 1) $display("FAIL mult_strobe_count: got %0d want 1", n_strobe); else n_pass++;
    n_checks++; if (m.wdog_err !== 1'b0) $display("FAIL mult_wdog: got %b want 0", m.wdog_err); else n_pass++;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // MTHI occupies E for its accept and START cycles; MFLO behind it is held for those two.
  task automatic test_mthi_mflo();
    logic [3:0] exp_stall;
    int         n_stall;
    exp_stall = 4'b0011;
    n_stall   = 0;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive(1'b1, 4'd6, (c == 0) ? 32'h1234 : 32'h9999, 32'h0, 1'b0, 1'b0);
      else       drive(1'b1, 4'd9, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      if (m.stall) n_stall++;
      n_checks++; if (m.stall !== exp_stall[c]) $display("FAIL mthi_stall c%0d: got %b want %b", c, m.stall, exp_stall[c]); else n_pass++;
      n_checks++; if (strobes() !== ((c == 1) ? 7'b0100000 : 7'b0)) $display("FAIL mthi_strobes c%0d: got %b", c, strobes()); else n_pass++;
      if (c == 1) begin
        n_checks++; if (m.md_data1 !== 32'h1234) $display("FAIL mthi_data1: got %h want 00001234", m.md_data1); else n_pass++;
      end
      next_cycle();
    end
    n_checks++; if (n_stall !== 2) $display("FAIL mthi_stall_count: got %0d want 2", n_stall); else n_pass++;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // DIVU by zero, then DIV by 5; md_busy stays low so BUSY lasts one cycle.
  task automatic test_div_zero();
    logic [3:0] codes [2];
    logic [31:0] rts [2];
    logic [6:0] exp_strb [2];
    logic       exp_dz [2];
    codes = '{4'd4, 4'd3};
    rts   = '{32'd0, 32'd5};
    exp_strb = '{7'b0001000, 7'b0000100};
    exp_dz   = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 5; c++) begin
        if (c < 4) drive(1'b1, codes[k], 32'd100, rts[k], 1'b0, 1'b0);
        else       drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (m.stall !== (c < 4)) $display("FAIL div%0d_stall c%0d: got %b want %b", k, c, m.stall, (c < 4)); else n_pass++;
        n_checks++; if (strobes() !== ((c == 1) ? exp_strb[k] : 7'b0)) $display("FAIL div%0d_strobes c%0d: got %b", k, c, strobes()); else n_pass++;
        n_checks++; if (m.div_zero !== ((c == 1) && exp_dz[k])) $display("FAIL div%0d_zero c%0d: got %b want %b", k, c, m.div_zero, (c == 1) && exp_dz[k]); else n_pass++;
        next_cycle();
      end
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Flushed MULT and non-MD codes: no stall, no strobe, state stays IDLE.
  task automatic test_flush_nonmd();
    logic [3:0] codes [4];
    logic       fl [4];
    codes = '{4'd1, 4'd0, 4'd10, 4'd15};
    fl    = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, codes[k], 32'h77, 32'h88, fl[k], 1'b0);
      @(negedge clk);
      n_checks++; if (m.stall !== 1'b0) $display("FAIL ignore%0d_stall: got %b want 0", k, m.stall); else n_pass++;
      next_cycle();
      drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++; if (strobes() !== 7'b0) $display("FAIL ignore%0d_strobes: got %b want 0", k, strobes()); else n_pass++;
      n_checks++; if (m.stall !== 1'b0) $display("FAIL ignore%0d_idle: got %b want 0", k, m.stall); else n_pass++;
      next_cycle();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // MADD with md_busy stuck high: BUSY spans cycles 3..2+WDOG, IDLE with error at 3+WDOG.
  task automatic test_watchdog();
    for (int c = 0; c < int'(WDOG) + 6; c++) begin
      if (c < 2) drive(1'b1, 4'd5, 32'h1, 32'h2, 1'b0, 1'b0);
      else       drive(1'b1, 4'd8, 32'h0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++; if (m.stall !== (c <= int'(WDOG) + 2)) $display("FAIL wdog_stall c%0d: got %b want %b", c, m.stall, (c <= int'(WDOG) + 2)); else n_pass++;
      n_checks++; if (m.wdog_err !== (c >= int'(WDOG) + 3)) $display("FAIL wdog_err c%0d: got %b want %b", c, m.wdog_err, (c >= int'(WDOG) + 3)); else n_pass++;
      if (c == 1) begin
        n_checks++; if (strobes() !== 7'b0010000) $display("FAIL wdog_madd: got %b want 0010000", strobes()); else n_pass++;
      end
      next_cycle();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) next_cycle();
    @(negedge clk);
    n_checks++; if (m.wdog_err !== 1'b1) $display("FAIL wdog_sticky: got %b want 1", m.wdog_err); else n_pass++;
    next_cycle();
  endtask

  // Reset during GAP of a MULT, then a clean MULT 5 * 6.
  task automatic test_reset_in_gap();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'd1, 32'h0A, 32'h0B, 1'b0, c == 1);
      next_cycle();
    end
    drive(1'b1, 4'd1, 32'h0A, 32'h0B, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (m.stall !== 1'b0) $display("FAIL rgap_stall: got %b want 0", m.stall); else n_pass++;
    n_checks++; if ({strobes(), m.div_zero, m.wdog_err} !== 9'b0) $display("FAIL rgap_flags: got %b want 0", {strobes(), m.div_zero, m.wdog_err}); else n_pass++;
    n_checks++; if ({m.md_data1, m.md_data2} !== 64'd0) $display("FAIL rgap_data: got %h want 0", {m.md_data1, m.md_data2}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (strobes() !== 7'b0) $display("FAIL rgap_hold_strobes: got %b want 0", strobes()); else n_pass++;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1'b1, 4'd1, 32'd5, 32'd6, 1'b0, 1'b0);
      else       drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++; if (m.stall !== (c < 4)) $display("FAIL rgap_mult_stall c%0d: got %b want %b", c, m.stall, (c < 4)); else n_pass++;
      n_checks++; if (strobes() !== ((c == 1) ? 7'b0000001 : 7'b0)) $display("FAIL rgap_mult_strobes c%0d: got %b", c, strobes()); else n_pass++;
      if (c == 1) begin
        n_checks++; if ({m.md_data1, m.md_data2} !== {32'd5, 32'd6}) $display("FAIL rgap_mult_data: got %h want %h", {m.md_data1, m.md_data2}, {32'd5, 32'd6}); else n_pass++;
      end
      next_cycle();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_mult();
    test_mthi_mflo();
    test_div_zero();
    test_flush_nonmd();
    test_watchdog();
    test_reset_in_gap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
